// File: rtl/fifo_enqueue_arbiter_pkg.sv
// Shared types and default sizing for the arbitrated enqueue FIFO.
package fifo_enqueue_arbiter_pkg;
    localparam int NUM_REQUESTERS         = 4;
    localparam int WIDTH                  = 32;
    localparam int FIFO_SIZE              = 8;
    localparam int ALMOST_FULL_THRESHOLD  = 6;
    localparam int ALMOST_EMPTY_THRESHOLD = 2;

    typedef logic [$clog2(NUM_REQUESTERS)-1:0] requester_idx_t;

    typedef struct packed {
        requester_idx_t     source;
        logic [WIDTH-1:0]   data;
    } fifo_entry_t;
endpackage

// File: rtl/fifo_enqueue_arbiter_if.sv
// Producer/consumer bundle for fifo_enqueue_arbiter; master = client side, slave = queue side.
interface fifo_enqueue_arbiter_if #(
    parameter int NUM_REQUESTERS = fifo_enqueue_arbiter_pkg::NUM_REQUESTERS,
    parameter int WIDTH          = fifo_enqueue_arbiter_pkg::WIDTH,
    parameter int FIFO_SIZE      = fifo_enqueue_arbiter_pkg::FIFO_SIZE
);
    localparam int SRC_W = $clog2(NUM_REQUESTERS);
    localparam int CNT_W = $clog2(FIFO_SIZE + 1);

    logic [NUM_REQUESTERS-1:0]            request_valid;
    logic [NUM_REQUESTERS-1:0][WIDTH-1:0] request_data;
    logic [NUM_REQUESTERS-1:0]            request_grant;
    logic                                 flush_en;
    logic                                 dequeue_en;
    logic [WIDTH-1:0]                     dequeue_value;
    logic [SRC_W-1:0]                     dequeue_source;
    logic                                 empty;
    logic                                 almost_empty;
    logic                                 full;
    logic                                 almost_full;
    logic [CNT_W-1:0]                     occupancy;

    modport master (
        output request_valid, request_data, flush_en, dequeue_en,
        input  request_grant, dequeue_value, dequeue_source,
               empty, almost_empty, full, almost_full, occupancy
    );

    modport slave (
        input  request_valid, request_data, flush_en, dequeue_en,
        output request_grant, dequeue_value, dequeue_source,
               empty, almost_empty, full, almost_full, occupancy
    );
endinterface

// File: rtl/fifo_enqueue_arbiter_sync_fifo.sv
// Single-clock circular FIFO with flush and occupancy-derived status flags.
module sync_fifo #(
    parameter int WIDTH                  = 34,
    parameter int SIZE                   = 8,
    parameter int ALMOST_FULL_THRESHOLD  = 6,
    parameter int ALMOST_EMPTY_THRESHOLD = 2,
    localparam int CNT_W                 = $clog2(SIZE + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_en_i,
    input  logic             enqueue_en_i,
    input  logic [WIDTH-1:0] enqueue_value_i,
    input  logic             dequeue_en_i,
    output logic [WIDTH-1:0] dequeue_value_o,
    output logic             full_o,
    output logic             almost_full_o,
    output logic             empty_o,
    output logic             almost_empty_o,
    output logic [CNT_W-1:0] occupancy_o
);
    localparam int PTR_W = $clog2(SIZE);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop;

    // Illegal pops and pushes into a full queue are masked so state never corrupts.
    assign push = enqueue_en_i && !full_o && !flush_en_i;
    assign pop  = dequeue_en_i && !empty_o && !flush_en_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_en_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[tail_q] <= enqueue_value_i;
    end

    assign dequeue_value_o = mem_q[head_q];
    assign occupancy_o     = count_q;
    assign full_o          = (count_q == CNT_W'(SIZE));
    assign empty_o         = (count_q == '0);
    assign almost_full_o   = (count_q >= CNT_W'(ALMOST_FULL_THRESHOLD));
    assign almost_empty_o  = (count_q <= CNT_W'(ALMOST_EMPTY_THRESHOLD));

    a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        dequeue_en_i |-> !empty_o);
endmodule

// File: rtl/fifo_enqueue_arbiter.sv
// Round-robin arbitration of NUM_REQUESTERS producers into one shared sync_fifo,
// tagging each entry with its source index.
module fifo_enqueue_arbiter
    import fifo_enqueue_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS         = fifo_enqueue_arbiter_pkg::NUM_REQUESTERS,
    parameter int WIDTH                  = fifo_enqueue_arbiter_pkg::WIDTH,
    parameter int FIFO_SIZE              = fifo_enqueue_arbiter_pkg::FIFO_SIZE,
    parameter int ALMOST_FULL_THRESHOLD  = fifo_enqueue_arbiter_pkg::ALMOST_FULL_THRESHOLD,
    parameter int ALMOST_EMPTY_THRESHOLD = fifo_enqueue_arbiter_pkg::ALMOST_EMPTY_THRESHOLD
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_enqueue_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_REQUESTERS);
    localparam int ENT_W = SRC_W + WIDTH;

    logic [SRC_W-1:0]          ptr_q;
    logic [SRC_W-1:0]          gidx;
    logic [NUM_REQUESTERS-1:0] grant;
    logic                      found;
    logic [ENT_W-1:0]          enq_entry, head_entry;

    // Search upward from the priority pointer; eligibility uses the registered full.
    always_comb begin
        int idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        if (!reset && !bus.full && !bus.flush_en) begin
            for (int k = 0; k < NUM_REQUESTERS; k++) begin
                idx = (int'(ptr_q) + k) % NUM_REQUESTERS;
                if (!found && bus.request_valid[idx]) begin
                    grant[idx] = 1'b1;
                    gidx       = idx[SRC_W-1:0];
                    found      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_q <= '0;
        else if (found)
            ptr_q <= (int'(gidx) == NUM_REQUESTERS - 1) ? '0 : gidx + 1'b1;
    end

    assign bus.request_grant = grant;
    assign enq_entry         = {gidx, bus.request_data[gidx]};

    sync_fifo #(
        .WIDTH                  (ENT_W),
        .SIZE                   (FIFO_SIZE),
        .ALMOST_FULL_THRESHOLD  (ALMOST_FULL_THRESHOLD),
        .ALMOST_EMPTY_THRESHOLD (ALMOST_EMPTY_THRESHOLD)
    ) u_fifo (
        .clk_i           (clk),
        .rst_i           (reset),
        .flush_en_i      (bus.flush_en),
        .enqueue_en_i    (found),
        .enqueue_value_i (enq_entry),
        .dequeue_en_i    (bus.dequeue_en),
        .dequeue_value_o (head_entry),
        .full_o          (bus.full),
        .almost_full_o   (bus.almost_full),
        .empty_o         (bus.empty),
        .almost_empty_o  (bus.almost_empty),
        .occupancy_o     (bus.occupancy)
    );

    assign bus.dequeue_source = head_entry[ENT_W-1:WIDTH];
    assign bus.dequeue_value  = head_entry[WIDTH-1:0];
endmodule

// File: doc/fifo_enqueue_arbiter.md
Name: fifo_enqueue_arbiter

Overview:
- Shares one sync_fifo instance among NUM_REQUESTERS producers.
- A round-robin arbiter chooses one producer per cycle and enqueues its data plus its source index. A single consumer drains entries in FIFO order.
- Sits in front of shared queues such as the L2 request queue and I/O request queue, replacing per-requester FIFOs.

Parameters:
- NUM_REQUESTERS, 4, number of producers; must be at least 2.
- WIDTH, 32, payload width in bits.
- FIFO_SIZE, 8, queue depth in entries; must be a power of two.
- ALMOST_FULL_THRESHOLD, 6, occupancy at or above which almost_full asserts.
- ALMOST_EMPTY_THRESHOLD, 2, occupancy at or below which almost_empty asserts.

Ports:
- clk  input  1  clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- request_valid  input  NUM_REQUESTERS  per-requester request; held until granted.
- request_data  input  NUM_REQUESTERS x WIDTH  per-requester payload; held stable while request_valid is high.
- request_grant  output  NUM_REQUESTERS  one-hot grant, combinational; the payload is enqueued on the same edge.
- flush_en  input  1  discards all queued entries.
- dequeue_en  input  1  pops the head entry.
- dequeue_value  output  WIDTH  payload of the head entry; valid when empty is 0.
- dequeue_source  output  $clog2(NUM_REQUESTERS)  index of the requester that produced the head entry.
- empty  output  1  queue holds no entries.
- almost_empty  output  1  occupancy <= ALMOST_EMPTY_THRESHOLD.
- full  output  1  occupancy == FIFO_SIZE.
- almost_full  output  1  occupancy >= ALMOST_FULL_THRESHOLD.
- occupancy  output  $clog2(FIFO_SIZE+1)  registered entry count.

Behaviour:
- Reset values:
  - Priority pointer 0, occupancy 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - request_grant forced to 0 while reset is high.
- Grant eligibility: request_grant is nonzero only if all of the following hold: request_valid is nonzero, full==0, flush_en==0.
- Grant selection: the first valid requester found by searching upward from the priority pointer, wrapping from NUM_REQUESTERS-1 to 0.
- Pointer update: on a grant to requester i, the pointer becomes (i+1) mod NUM_REQUESTERS on the next edge. With no grant, the pointer holds.
- Enqueue: a grant pulses sync_fifo enqueue_en the same cycle, writing {i, request_data[i]}. The requester sees the grant and may drop valid or present new data next cycle.
- Dequeue:
  - dequeue_value and dequeue_source reflect the head entry combinationally.
  - dequeue_en pops on the edge.
  - dequeue_en while empty is illegal; it is asserted against in simulation and does not change state.
- Occupancy update:
  - +1 on grant without dequeue.
  - -1 on dequeue without grant.
  - Unchanged when both occur.
  - Status outputs derive from occupancy with the thresholds above.
- Full with simultaneous dequeue: no grant is issued. Grant eligibility depends on the registered full, not on the same-cycle dequeue. Occupancy goes FIFO_SIZE -> FIFO_SIZE-1.
- Empty with simultaneous grant: the entry becomes visible at the head the next cycle, not in the same cycle.
- Flush:
  - Takes precedence over enqueue and dequeue in the same cycle.
  - Next cycle: occupancy=0, empty=1.
  - The priority pointer is unchanged.
- Reset mid-operation: all queued entries are lost and the pointer returns to 0. Requesters that are still valid are re-arbitrated after reset deasserts.
- Ordering:
  - Entries dequeue in global grant order.
  - A requester holding valid continuously is granted at least once every NUM_REQUESTERS grant cycles.

Decomposition:
- Shared package defines:
  - requester_idx_t as logic[$clog2(NUM_REQUESTERS)-1:0] at the default width.
  - The fifo entry struct {requester_idx_t source; logic[WIDTH-1:0] data}.
- Sub-modules:
  - Reuse the existing sync_fifo with WIDTH = $bits(entry) and pass through its thresholds.
  - Reuse the existing rr_arbiter for selection only if it matches the pointer rule above; otherwise implement selection inline.

Test Plan:
- Priority sequence: all 4 requesters hold valid from reset with data 0x10+i → grants in order 0,1,2,3,0,… and the consumer reads sources 0,1,2,3 with values 0x10,0x11,0x12,0x13.
- Fill and single dequeue: requester 2 alone is valid for 10 cycles, no dequeue → 8 grants, full=1 after the 8th, no further grant, almost_full=1 from occupancy 6. One dequeue_en while full and valid → no grant that cycle, and occupancy becomes 7.
- Drain: fill to 8, then dequeue every cycle → almost_full clears at 5, almost_empty sets at 2, empty=1 after the 8th pop, and values match enqueue order.
- Concurrent traffic: occupancy 3, grant and dequeue_en in the same cycle → occupancy stays 3 and the head advances.
- Flush: occupancy 5, flush_en together with request_valid=4'b0001 → no grant that cycle, next cycle occupancy=0 and empty=1, and requester 0 is granted the following cycle.
- Reset mid-run: assert reset with occupancy 4 and pointer at 3 → immediately empty=1 and request_grant=0. After deassert, with requesters 1 and 3 valid, the first grant goes to 1 (pointer 0).
